// File: rtl/fixed_divider_if.sv
// Valid/ready operand and result bundle for fixed_divider.
// master = operand producer / result consumer, slave = the divider.
interface fixed_divider_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic             overflow;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, overflow, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, overflow, div_by_zero
  );
endinterface

// File: rtl/fixed_divider.sv
// Sequential signed Q(WIDTH-FRAC).FRAC divider: radix-2 restoring division on magnitudes,
// one quotient bit per clock. Define FIXED_DIVIDER_ROUND_EN for round-half-away-from-zero.
module fixed_divider #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  fixed_divider_if.slave bus
);

`ifdef FIXED_DIVIDER_ROUND_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int ITER  = WIDTH + FRAC;
  localparam int NBITS = ITER + EXTRA;
  localparam int CW    = $clog2(NBITS + 1);

  localparam logic [WIDTH-1:0] Q_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] Q_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [NBITS-1:0] MAG_POS = NBITS'(Q_MAX);
  localparam logic [NBITS-1:0] MAG_NEG = NBITS'(Q_MIN);

  typedef enum logic [1:0] {IDLE, CALC, FINAL, HOLD} state_t;

  state_t           r_state;
  logic [NBITS-1:0] r_num;
  logic [NBITS-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sign;
  logic             r_a_neg;
  logic             r_dz;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quot;
  logic             r_ovf;
  logic             r_dzo;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [NBITS-1:0] w_mag;
  logic [WIDTH-1:0] w_res_q;
  logic             w_res_ovf;

  // Two's-complement negation of the most negative value yields its true magnitude as unsigned.
  assign w_a_mag = bus.dividend[WIDTH-1] ? WIDTH'(-bus.dividend) : bus.dividend;
  assign w_b_mag = bus.divisor[WIDTH-1]  ? WIDTH'(-bus.divisor)  : bus.divisor;

  assign w_trial = {r_rem, r_num[NBITS-1]};
  assign w_ge    = (w_trial >= {1'b0, r_dvs});
  assign w_diff  = w_trial - {1'b0, r_dvs};

`ifdef FIXED_DIVIDER_ROUND_EN
  assign w_mag = (r_q >> 1) + NBITS'(r_q[0]);
`else
  assign w_mag = r_q;
`endif

  always_comb begin
    w_res_q   = '0;
    w_res_ovf = 1'b0;
    if (r_dz) begin
      w_res_q = r_a_neg ? Q_MIN : Q_MAX;
    end else if (!r_sign && (w_mag > MAG_POS)) begin
      w_res_q   = Q_MAX;
      w_res_ovf = 1'b1;
    end else if (r_sign && (w_mag > MAG_NEG)) begin
      w_res_q   = Q_MIN;
      w_res_ovf = 1'b1;
    end else begin
      w_res_q = r_sign ? WIDTH'(-w_mag[WIDTH-1:0]) : w_mag[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_num   <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_sign  <= 1'b0;
      r_a_neg <= 1'b0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_ovf   <= 1'b0;
      r_dzo   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_num   <= {w_a_mag, {(NBITS-WIDTH){1'b0}}};
            r_q     <= '0;
            r_rem   <= '0;
            r_dvs   <= w_b_mag;
            r_sign  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_a_neg <= bus.dividend[WIDTH-1];
            r_dz    <= (bus.divisor == '0);
            r_cnt   <= '0;
            r_state <= (bus.divisor == '0) ? FINAL : CALC;
          end
        end
        CALC: begin
          // Remainder stays below |divisor| <= 2^(WIDTH-1), so WIDTH bits always hold it.
          r_rem   <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_q     <= {r_q[NBITS-2:0], w_ge};
          r_num   <= r_num << 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(NBITS - 1)) begin
            r_state <= FINAL;
          end
        end
        FINAL: begin
          r_quot  <= w_res_q;
          r_ovf   <= w_res_ovf;
          r_dzo   <= r_dz;
          r_state <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.out_valid   = (r_state == HOLD);
  assign bus.quotient    = r_quot;
  assign bus.overflow    = r_ovf;
  assign bus.div_by_zero = r_dzo;

endmodule

// File: tb/tb_fixed_divider.sv
// Self-checking bench for fixed_divider: directed corner cases plus randomized operands
// checked against an integer-arithmetic reference model.
module tb_fixed_divider;
  localparam int W    = 16;
  localparam int F    = 11;
  localparam int ITER = W + F;
`ifdef FIXED_DIVIDER_ROUND_EN
  localparam bit RND = 1'b1;
  localparam int LAT = ITER + 2;
`else
  localparam bit RND = 1'b0;
  localparam int LAT = ITER + 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fixed_divider_if #(.WIDTH(W)) bus ();

  fixed_divider #(.WIDTH(W), .FRAC(F)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q;
  logic         exp_ov;
  logic         exp_dz;
  bit           exp_set = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns {div_by_zero, overflow, quotient} from plain signed integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, ma, mb, mag, lim;
    bit neg;
    logic [W-1:0] qmax, qmin, q;
    qmax = {1'b0, {(W-1){1'b1}}};
    qmin = {1'b1, {(W-1){1'b0}}};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return {2'b10, (sa >= 0) ? qmax : qmin};
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sb < 0) ? -sb : sb;
    neg = (sa < 0) != (sb < 0);
    if (RND) mag = (((ma << (F + 1)) / mb) + 1) >> 1;
    else     mag = (ma << F) / mb;
    lim = longint'(1) << (W - 1);
    if (!neg && mag > lim - 1) return {2'b01, qmax};
    if (neg && mag > lim)      return {2'b01, qmin};
    q = neg ? W'(-mag) : W'(mag);
    return {2'b00, q};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (!exp_set) begin
        check("unexpected out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        check("quotient", 32'(bus.quotient), 32'(exp_q));
        check("overflow", 32'(bus.overflow), 32'(exp_ov));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(exp_dz));
      end
    end
  end

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W+1:0] m;
    @(negedge clk);
    check("in_ready before accept", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    m      = model(a, b);
    exp_q  = m[W-1:0];
    exp_ov = m[W];
    exp_dz = m[W+1];
    exp_set = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    int n;
    start(a, b);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
  endtask

  task automatic consume(input bit with_valid);
    @(negedge clk);
    bus.out_ready = 1'b1;
    if (with_valid) begin
      bus.in_valid = 1'b1;
      bus.dividend = 16'h1800;
      bus.divisor  = 16'h0C00;
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    exp_set = 1'b0;
    check("out_valid after consume", 32'(bus.out_valid), 32'd0);
    check("in_ready after consume", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic pin(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                     input logic ov, input logic dz, input int lat);
    check("model literal", 32'(model(a, b)), 32'({dz, ov, q}));
    op(a, b, lat);
    check("literal quotient", 32'(bus.quotient), 32'(q));
    check("literal flags", 32'({bus.div_by_zero, bus.overflow}), 32'({dz, ov}));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb, held;
    int sel, dly;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    #12;
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset quotient", 32'(bus.quotient), 32'd0);
    check("reset flags", 32'({bus.div_by_zero, bus.overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("in_ready after reset", 32'(bus.in_ready), 32'd1);

    pin(16'h1800, 16'h0C00, 16'h1000, 1'b0, 1'b0, LAT); consume(1'b0);
    pin(16'hE800, 16'h0C00, 16'hF000, 1'b0, 1'b0, LAT); consume(1'b0);
    pin(16'h0800, 16'h1800, RND ? 16'h02AB : 16'h02AA, 1'b0, 1'b0, LAT); consume(1'b0);
    pin(16'h7800, 16'h0001, 16'h7FFF, 1'b1, 1'b0, LAT); consume(1'b0);
    pin(16'h8000, 16'hF800, 16'h7FFF, 1'b1, 1'b0, LAT); consume(1'b0);
    pin(16'h8000, 16'h0800, 16'h8000, 1'b0, 1'b0, LAT); consume(1'b0);
    pin(16'h0800, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1);   consume(1'b0);
    pin(16'hF800, 16'h0000, 16'h8000, 1'b0, 1'b1, 1);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = 16'($urandom);
      bus.divisor  = 16'h0001;
      @(posedge clk);
      #1;
      check("hold in_ready", 32'(bus.in_ready), 32'd0);
      check("hold out_valid", 32'(bus.out_valid), 32'd1);
      check("hold quotient", 32'(bus.quotient), 32'h8000);
      check("hold div_by_zero", 32'(bus.div_by_zero), 32'd1);
    end
    bus.in_valid = 1'b0;
    consume(1'b1);

    start(16'h0800, 16'h1800);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_set = 1'b0;
    check("abort out_valid", 32'(bus.out_valid), 32'd0);
    check("abort quotient", 32'(bus.quotient), 32'd0);
    check("abort flags", 32'({bus.div_by_zero, bus.overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("in_ready after abort", 32'(bus.in_ready), 32'd1);
    pin(16'h1800, 16'h0C00, 16'h1000, 1'b0, 1'b0, LAT); consume(1'b0);

    for (int i = 0; i < 300; i++) begin
      ra  = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0)     rb = '0;
      else if (sel < 4) rb = 16'($urandom_range(1, 64));
      else              rb = 16'($urandom);
      if (sel != 0 && $urandom_range(0, 1) == 1) rb = 16'(-rb);
      op(ra, rb, (rb == '0) ? 1 : LAT);
      held = bus.quotient;
      dly  = $urandom_range(0, 3);
      repeat (dly) @(posedge clk);
      #1;
      check("stable under backpressure", 32'(bus.quotient), 32'(held));
      consume(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
